// File: rtl/first_system_led_seq_pkg.sv
// Shared definitions for the LED sequencer: register map, CTRL bit positions, FSM states.
// No logic; no latency.
// No flow control.
package first_system_led_seq_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_DIR    = 1;
    localparam int CTRL_BOUNCE = 2;

    localparam int STEPS_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Field order matches CTRL readback bits [2:0].
    typedef struct packed {
        logic bounce;
        logic dir;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/first_system_led_seq_timer.sv
// Period down-counter: load, decrement-to-zero, zero flag.
// Zero flag is combinational from the count register; one cycle per decrement.
// No backpressure; saturates at zero.
module first_system_led_seq_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/first_system_led_sequencer.sv
// Avalon-MM LED sequencer: rotates a pattern and writes it to a PIO every PERIOD cycles (bounce via FIRST_SYSTEM_LED_SEQ_BOUNCE_EN).
// Master write issued the cycle after RUN/expiry; readdata is combinational.
// Master write held stable while m_waitrequest=1; slave side never stalls.
module first_system_led_sequencer
    import first_system_led_seq_pkg::*;
#(
    parameter int LED_W = 8,
    parameter int CNT_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] period_q;
    logic [LED_W-1:0] pattern_q, pend_q, pattern_adv, pend_val;
    logic             pend_vld_q;
    logic [15:0]      steps_q;
    logic             dir_adv;
    logic             wr, wr_ctrl, wr_period, wr_pattern, wr_status;
    logic             run_eff, xfer_done, pend_any, expire, timer_zero, busy;
    logic [CNT_W-1:0] load_val;
    logic             unused_wdata;

    assign wr         = chipselect && !write_n;
    assign wr_ctrl    = wr && (address == ADDR_CTRL);
    assign wr_period  = wr && (address == ADDR_PERIOD);
    assign wr_pattern = wr && (address == ADDR_PATTERN);
    assign wr_status  = wr && (address == ADDR_STATUS);

    // A CTRL write in flight counts immediately, so clearing RUN beats a same-cycle expiry.
    assign run_eff   = wr_ctrl ? writedata[CTRL_RUN] : ctrl_q.run;
    assign xfer_done = (state_q == ST_WRITE) && !m_waitrequest;
    assign pend_any  = pend_vld_q || wr_pattern;
    assign pend_val  = wr_pattern ? writedata[LED_W-1:0] : pend_q;
    assign expire    = (state_q == ST_WAIT) && timer_zero && run_eff && !wr_pattern;
    assign busy      = (state_q != ST_IDLE);
    assign load_val  = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    assign unused_wdata = ^writedata;

    first_system_led_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (xfer_done),
        .load_val (load_val),
        .dec      (state_q == ST_WAIT),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run_eff) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (xfer_done) begin
                    if (pend_any)     state_d = ST_WRITE;
                    else if (run_eff) state_d = ST_WAIT;
                    else              state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!run_eff)                     state_d = ST_IDLE;
                else if (wr_pattern || timer_zero) state_d = ST_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_chipselect = (state_q == ST_WRITE);
        m_write_n    = (state_q != ST_WRITE);
        m_address    = 2'd0;
        m_writedata  = '0;
        m_writedata[LED_W-1:0] = pattern_q;
    end

`ifdef FIRST_SYSTEM_LED_SEQ_BOUNCE_EN
    // On hitting the leading edge, reverse and shift back with zero fill.
    always_comb begin
        dir_adv = ctrl_q.dir;
        if (!ctrl_q.dir) pattern_adv = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
        else             pattern_adv = {pattern_q[0], pattern_q[LED_W-1:1]};
        if (ctrl_q.bounce) begin
            if (!ctrl_q.dir && pattern_q[LED_W-1]) begin
                dir_adv     = 1'b1;
                pattern_adv = {1'b0, pattern_q[LED_W-1:1]};
            end else if (ctrl_q.dir && pattern_q[0]) begin
                dir_adv     = 1'b0;
                pattern_adv = {pattern_q[LED_W-2:0], 1'b0};
            end
        end
    end
`else
    always_comb begin
        dir_adv = ctrl_q.dir;
        if (!ctrl_q.dir) pattern_adv = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
        else             pattern_adv = {pattern_q[0], pattern_q[LED_W-1:1]};
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            period_q   <= '0;
            pattern_q  <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            steps_q    <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q.run <= writedata[CTRL_RUN];
                ctrl_q.dir <= writedata[CTRL_DIR];
`ifdef FIRST_SYSTEM_LED_SEQ_BOUNCE_EN
                ctrl_q.bounce <= writedata[CTRL_BOUNCE];
`else
                ctrl_q.bounce <= 1'b0;
`endif
            end else if (expire) begin
                ctrl_q.dir <= dir_adv;
            end

            if (wr_period) period_q <= writedata[CNT_W-1:0];

            // The pattern on the bus must not change mid-transfer, so WRITE-time updates wait.
            if (xfer_done && pend_any) begin
                pattern_q  <= pend_val;
                pend_vld_q <= 1'b0;
            end else if (wr_pattern && (state_q == ST_WRITE)) begin
                pend_q     <= writedata[LED_W-1:0];
                pend_vld_q <= 1'b1;
            end else if (wr_pattern) begin
                pattern_q <= writedata[LED_W-1:0];
            end else if (expire) begin
                pattern_q <= pattern_adv;
            end

            if (wr_status)      steps_q <= '0;
            else if (xfer_done) steps_q <= steps_q + 16'd1;
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_CTRL:    readdata[2:0] = ctrl_q;
            ADDR_PERIOD:  readdata[CNT_W-1:0] = period_q;
            ADDR_PATTERN: readdata[LED_W-1:0] = pattern_q;
            default: begin
                readdata[0] = busy;
                readdata[31:STEPS_LSB] = steps_q;
            end
        endcase
    end

endmodule

// File: doc/first_system_led_sequencer.md
FIRST_SYSTEM_LED_SEQUENCER -- requirements
Module: first_system_led_sequencer

Interface
REQ-001 SHALL have parameter LED_W, default 8, giving the LED pattern width (2..32).
REQ-002 SHALL have parameter CNT_W, default 24, giving the period counter width in clk cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have Avalon-MM slave ports: address in 2; chipselect in 1; write_n in 1; writedata in 32; readdata out 32.
REQ-006 SHALL have Avalon-MM master ports to the LED PIO: m_address out 2; m_chipselect out 1; m_write_n out 1; m_writedata out 32; m_waitrequest in 1.

Function
REQ-007 SHALL decode slave writes when chipselect=1 and write_n=0. Register map:
- 0 CTRL: bit0 RUN, bit1 DIR (0=left, 1=right), bit2 BOUNCE.
- 1 PERIOD: CNT_W bits; 0 treated as 1.
- 2 PATTERN: LED_W bits.
- 3 STATUS: bit0 BUSY, bits[31:16] STEPS; a write clears STEPS.
REQ-008 SHALL drive readdata combinationally from address, zero-extended; unused bits read 0.
REQ-009 SHALL implement FSM states IDLE, WRITE and WAIT; BUSY=1 whenever state is not IDLE.
REQ-010 IDLE: with RUN=1 -> WRITE on the next cycle.
REQ-011 WRITE: SHALL drive m_chipselect=1, m_write_n=0, m_address=0 and m_writedata=zero-extended pattern, held stable until m_waitrequest=0.
REQ-012 WRITE completion: the cycle with m_waitrequest=0 SHALL complete the transfer, increment STEPS (wrap 0xFFFF->0), load the counter with max(PERIOD,1)-1, then -> WAIT, or -> IDLE if RUN=0.
REQ-013 WAIT: counter decrements each cycle; at 0 the pattern advances one step and the FSM -> WRITE.
REQ-014 Advance (DIR=0): rotate left, p <= {p[LED_W-2:0], p[LED_W-1]}; DIR=1 is the mirror rotate right.
REQ-015 Bounce: when bounce is active and the bit at the leading edge is 1 (DIR=0: p[LED_W-1]; DIR=1: p[0]), SHALL toggle DIR and shift the opposite way, zero-filling; the updated DIR SHALL be visible in CTRL readback.
REQ-016 All-zero pattern: SHALL advance as zero and still be written every period.
REQ-017 PATTERN write in IDLE or WAIT: SHALL replace the pattern; in WAIT, SHALL force WRITE on the next cycle.
REQ-018 PATTERN write in WRITE: SHALL latch into a pending register; on completion it is applied and another WRITE follows immediately, regardless of RUN.
REQ-019 RUN cleared in WAIT: -> IDLE next cycle, no advance, even if the counter expires in the same cycle.
REQ-020 RUN cleared in WRITE: the transfer SHALL complete before -> IDLE; no aborted transfers.
REQ-021 A PERIOD write SHALL take effect at the next counter load only.

Reset
REQ-022 On reset_n=0 at posedge clk: state=IDLE and all registers 0 (CTRL, PERIOD, PATTERN, pending, STEPS, counter).
REQ-023 Outputs in reset: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, readdata=0.
REQ-024 Reset during WRITE SHALL drop the transfer immediately.

Configuration
REQ-025 Macro FIRST_SYSTEM_LED_SEQ_BOUNCE_EN defined: CTRL bit2 is writable and REQ-015 applies.
REQ-026 Macro undefined: bit2 reads 0, writes are ignored and no bounce logic is present; rotate only.

Structure
REQ-027 Package first_system_led_seq_pkg SHALL hold the register address constants, CTRL bit indices and the FSM state typedef.
REQ-028 Sub-module first_system_led_seq_timer (load/decrement/zero flag, CNT_W wide) SHALL implement the period counter.

Verification
REQ-029 PERIOD=4, PATTERN=0x01, RUN=1, waitrequest=0 -> m_writedata 0x01, 0x02, 0x04, ... with master writes spaced 5 cycles apart; STEPS increments per write.
REQ-030 m_waitrequest=1 for 3 cycles on first write -> writedata stable for 4 cycles, one STEPS increment.
REQ-031 Bounce macro on: PATTERN=0x40, DIR=0, BOUNCE=1 -> 0x40, 0x80, 0x40, 0x20; DIR reads 1 after 0x80.
REQ-032 PATTERN=0x5A written while in WRITE of 0x01 -> 0x01 completes, then 0x5A written next with no WAIT gap.
REQ-033 RUN cleared on the counter-expiry cycle -> IDLE, no further master write; PERIOD=0 -> writes 2 cycles apart.
REQ-034 reset_n=0 mid-WRITE -> next cycle m_chipselect=0, all reads 0; STATUS write clears STEPS to 0.
